sisc_fetch: RTL and testbench
=============================

Name: sisc_fetch

Overview:
Instruction fetch unit that generates the 32-bit instruction word `ir` consumed by the SISC core. It holds the program counter and issues word reads to instruction memory over a req/ack handshake, tolerating variable memory latency. Fetched words go into a 2-entry prefetch queue that presents `ir` to the control unit with valid/ready flow control. It also handles taken branches, which redirect the PC and flush the queue, and a halt input that stops new fetches.

Parameters:
ADDR_W, 16, instruction address width (word addressed)
RST_PC, 0, PC value loaded at reset
INCR, 1, PC increment per fetched word

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_f  input  1  synchronous reset, active-high
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  read address; valid while imem_req=1
imem_ack  input  1  memory has returned data this cycle; meaningful only while imem_req=1
imem_data  input  32  read data; sampled when imem_req&imem_ack
ir  output  32  instruction at queue head
ir_pc  output  ADDR_W  address of the word on ir
ir_valid  output  1  queue head holds a valid instruction
ir_ready  input  1  core consumes head this cycle when ir_valid&ir_ready
br_taken  input  1  one-cycle pulse: redirect fetch to br_addr
br_addr  input  ADDR_W  branch target
halt  input  1  level: no new requests issued while high
fetch_busy  output  1  request outstanding (state WAIT or DRAIN)

Behaviour:
- Reset (rst_f=1 at an edge):
  - imem_req=0, imem_addr=RST_PC, ir=0, ir_pc=0, ir_valid=0, fetch_busy=0.
  - Queue count=0, fetch_pc=RST_PC, state=IDLE.
  - Reset mid-transaction drops imem_req immediately; memory abandons the access.
- All outputs are registered. ir/ir_pc/ir_valid come from the queue head.
- Queue: 2 entries of {data, addr}.
  - Push on imem_req&imem_ack in state WAIT.
  - Pop on ir_valid&ir_ready.
  - Push and pop in the same cycle keep count unchanged.
- Only one request may be outstanding. A request is issued only when count_next<2, so a push can never overflow the queue.
- Handshake:
  - Once imem_req rises, imem_req and imem_addr stay stable until the edge at which imem_ack=1 is sampled.
  - The request is never withdrawn, except by reset.
- FSM states:
  - IDLE: imem_req=0. If !halt && count<2 → WAIT with imem_addr=fetch_pc, imem_req=1 next cycle.
  - WAIT: on ack, push {imem_data, imem_addr} and set fetch_pc=imem_addr+INCR (mod 2^ADDR_W, wraps). Then, if !halt && count_next<2, stay in WAIT with imem_addr=fetch_pc+INCR (imem_req stays high; back-to-back); else → IDLE. Without ack, hold.
  - DRAIN: imem_req stays high at the stale address. On ack, discard data → IDLE. The next cycle re-evaluates the issue condition against the redirected fetch_pc.
- Latency: with zero-wait memory (ack in the first req cycle):
  - imem_req=1 in the first cycle after reset deasserts.
  - ir_valid=1 one cycle after the ack edge.
  - Sustained throughput is one instruction per cycle when ir_ready=1.
- br_taken (highest priority after reset):
  - Queue flushed: count=0, ir_valid=0 next cycle. A simultaneous pop is ignored.
  - fetch_pc=br_addr.
  - If in WAIT without ack → DRAIN.
  - If in WAIT with ack in the same cycle → data discarded; go to WAIT with imem_addr=br_addr if !halt, else IDLE.
  - If in IDLE → issue at br_addr next cycle (unless halt).
  - If in DRAIN → remain in DRAIN, retarget fetch_pc.
  - br_taken while halted still updates fetch_pc and flushes the queue.
- halt:
  - Blocks new issue only. An outstanding request completes and is pushed.
  - Queue contents continue to drain to the core.
  - Deassertion resumes at fetch_pc.
- fetch_busy = state is WAIT or DRAIN.

Test Plan:
1. Reset: hold rst_f=1 for 3 cycles → imem_req=0, ir_valid=0, ir=0. First cycle after release → imem_req=1, imem_addr=0x0000.
2. Streaming: zero-wait memory returning data=addr+0x1000, ir_ready=1 → ir=0x1000,0x1001,0x1002 on consecutive cycles, ir_pc=0,1,2, imem_req continuously high.
3. Backpressure: ir_ready=0 → after 2 acks imem_req=0, ir=0x1000 held, ir_valid=1. Raise ir_ready for 1 cycle → ir=0x1001, new request issued at addr 2.
4. Branch during outstanding request: ack delay 3 cycles, br_taken with br_addr=0x0040 in the 2nd wait cycle → ir_valid=0 next cycle, the addr-0x0002 data is never presented, next imem_addr=0x0040, ir_pc=0x0040 on return.
5. Halt: raise halt while WAIT at addr 5 → ack enqueues addr 5 and no further req. Drop halt → request at addr 6. Also set fetch_pc=0xFFFF with halt low → fetch wraps to 0x0000.
6. Reset mid-transaction: assert rst_f while imem_req=1 and queue holds 1 entry → next cycle imem_req=0, ir_valid=0, and fetch restarts at 0x0000.

Source files
------------

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction fetch unit for the SISC core.
// Holds the PC, issues single-outstanding word reads over a req/ack
// handshake, buffers returned words in a 2-entry queue and presents the
// queue head to the control unit. Taken branches flush and redirect;
// halt stops new requests without abandoning the one in flight.
module sisc_fetch #(
  parameter int ADDR_W = 16,
  parameter int RST_PC = 0,
  parameter int INCR   = 1
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              halt,
  output logic              fetch_busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ir_valid_q, ir_valid_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   q0_data_q, q0_data_d, q1_data_q, q1_data_d;
  logic [ADDR_W-1:0]   q0_pc_q, q0_pc_d, q1_pc_q, q1_pc_d;

  logic                ack;
  logic                pop;
  logic                push;
  logic                wr_hi;
  logic [ADDR_W-1:0]   nxt_pc;

  // Next-state: fetch FSM, PC, queue occupancy and queue contents.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    q0_data_d  = q0_data_q;
    q0_pc_d    = q0_pc_q;
    q1_data_d  = q1_data_q;
    q1_pc_d    = q1_pc_q;

    ack    = req_q & imem_ack;
    pop    = ir_valid_q & ir_ready;
    push   = (state_q == S_WAIT) & ack & ~br_taken;
    nxt_pc = addr_q + ADDR_W'(INCR);
    // Slot the pushed word lands in, after any same-cycle pop has shifted.
    wr_hi  = (cnt_q - 2'(pop)) != 2'd0;

    if (br_taken) begin
      // Redirect wins over everything: flush, retarget, and either
      // abandon the in-flight data (DRAIN) or reissue at the target.
      cnt_d      = 2'd0;
      fetch_pc_d = br_addr;
      case (state_q)
        S_IDLE: begin
          if (!halt) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            addr_d  = br_addr;
          end
        end
        S_WAIT, S_DRAIN: begin
          if (ack) begin
            if (!halt) begin
              state_d = S_WAIT;
              req_d   = 1'b1;
              addr_d  = br_addr;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end else begin
            // Request must stay stable until acked; its data is dropped.
            state_d = S_DRAIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      case (state_q)
        S_IDLE: begin
          if (!halt && cnt_q < 2'd2) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        S_WAIT: begin
          if (ack) begin
            fetch_pc_d = nxt_pc;
            if (!halt && cnt_d < 2'd2) begin
              addr_d = nxt_pc;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (ack) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (pop) begin
        q0_data_d = q1_data_q;
        q0_pc_d   = q1_pc_q;
      end
      if (push) begin
        if (wr_hi) begin
          q1_data_d = imem_data;
          q1_pc_d   = addr_q;
        end else begin
          q0_data_d = imem_data;
          q0_pc_d   = addr_q;
        end
      end
    end

    ir_valid_d = (cnt_d != 2'd0);
    busy_d     = (state_d != S_IDLE);
  end

  // State registers; reset also clears the queue so ir/ir_pc read zero.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= ADDR_W'(RST_PC);
      addr_q     <= ADDR_W'(RST_PC);
      req_q      <= 1'b0;
      cnt_q      <= 2'd0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      q0_data_q  <= '0;
      q0_pc_q    <= '0;
      q1_data_q  <= '0;
      q1_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
      q0_data_q  <= q0_data_d;
      q0_pc_q    <= q0_pc_d;
      q1_data_q  <= q1_data_d;
      q1_pc_q    <= q1_pc_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir         = q0_data_q;
  assign ir_pc      = q0_pc_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_busy = busy_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: latency-programmable memory model, scoreboard of
// expected {ir, ir_pc} pairs checked whenever the core side consumes.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        halt;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;
  int unsigned lat  = 0;
  int unsigned mcnt = 0;
  int nconsumed = 0;
  logic [47:0] exp_q[$];
  logic [47:0] e;

  sisc_fetch #(.ADDR_W(16), .RST_PC(0), .INCR(1)) dut (
    .clk(clk), .rst_f(rst_f),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_addr(br_addr), .halt(halt), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // Memory: acks after `lat` extra cycles of a stable request, data = addr+0x1000.
  always @(negedge clk) begin
    imem_ack  = imem_req && (mcnt == lat);
    imem_data = {16'h0, imem_addr} + 32'h1000;
  end
  always @(posedge clk) begin
    if (rst_f || !imem_req || imem_ack) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic push_exp(input logic [15:0] a);
    exp_q.push_back({{16'h0, a} + 32'h1000, a});
  endtask

  task automatic apply_reset();
    rst_f = 1'b1; br_taken = 1'b0; br_addr = 16'h0; halt = 1'b0; ir_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_f = 1'b0;
    exp_q.delete();
    nconsumed = 0;
  endtask

  task automatic test_reset();
    rst_f = 1'b1; br_taken = 1'b0; br_addr = 16'h0; halt = 1'b0; ir_ready = 1'b0; lat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir: got %h want 0", ir); end
    total++; if (ir_pc !== 16'h0 || imem_addr !== 16'h0) begin bad++; $display("FAIL reset_pc: ir_pc=%h addr=%h want 0", ir_pc, imem_addr); end
    total++; if (fetch_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", fetch_busy); end
    rst_f = 1'b0;
    exp_q.delete();
    nconsumed = 0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin bad++; $display("FAIL first_req: req=%b addr=%h want 1/0000", imem_req, imem_addr); end
  endtask

  // Continues straight from test_reset with zero-wait memory and ir_ready low.
  task automatic test_backpressure();
    bit seen;
    push_exp(16'h0); push_exp(16'h1); push_exp(16'h2);
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_stop: got %b want 0", imem_req); end
    total++; if (ir_valid !== 1'b1 || ir !== 32'h1000 || ir_pc !== 16'h0) begin bad++; $display("FAIL bp_hold: valid=%b ir=%h pc=%h want 1/00001000/0000", ir_valid, ir, ir_pc); end
    ir_ready = 1'b1;
    if (ir_valid && ir_ready) begin
      total++; nconsumed++;
      e = exp_q.pop_front();
      if ({ir, ir_pc} !== e) begin bad++; $display("FAIL bp_consume: got %h/%h want %h/%h", ir, ir_pc, e[47:16], e[15:0]); end
    end
    @(negedge clk);
    ir_ready = 1'b0;
    total++; if (ir_valid !== 1'b1 || ir !== 32'h1001 || ir_pc !== 16'h1) begin bad++; $display("FAIL bp_next: valid=%b ir=%h pc=%h want 1/00001001/0001", ir_valid, ir, ir_pc); end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1'b1;
    end
    total++; if (!seen || imem_addr !== 16'h2) begin bad++; $display("FAIL bp_reissue: seen=%b addr=%h want 1/0002", seen, imem_addr); end
  endtask

  task automatic test_streaming();
    apply_reset();
    lat = 0;
    ir_ready = 1'b1;
    for (int a = 0; a < 16; a++) push_exp(16'(a));
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (ir_valid && ir_ready) begin
        total++; nconsumed++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got %h/%h want none", ir, ir_pc); end
        else begin
          e = exp_q.pop_front();
          if ({ir, ir_pc} !== e) begin bad++; $display("FAIL stream_data: got %h/%h want %h/%h", ir, ir_pc, e[47:16], e[15:0]); end
        end
      end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req: cycle %0d got %b want 1", c, imem_req); end
      if (c >= 2) begin
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL stream_valid: cycle %0d got %b want 1", c, ir_valid); end
      end
    end
    total++; if (nconsumed != 10) begin bad++; $display("FAIL stream_count: got %0d want 10", nconsumed); end
    ir_ready = 1'b0;
  endtask

  task automatic test_branch();
    int w2, phase;
    apply_reset();
    lat = 3;
    ir_ready = 1'b1;
    push_exp(16'h0); push_exp(16'h1);
    w2 = 0; phase = 0;
    for (int c = 0; c < 80 && phase < 4; c++) begin
      @(negedge clk);
      if (ir_valid && ir_ready) begin
        total++; nconsumed++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL br_extra: got %h/%h want none", ir, ir_pc); end
        else begin
          e = exp_q.pop_front();
          if ({ir, ir_pc} !== e) begin bad++; $display("FAIL br_data: got %h/%h want %h/%h", ir, ir_pc, e[47:16], e[15:0]); end
        end
      end
      case (phase)
        0: begin
          if (imem_req && imem_addr == 16'h2) w2++;
          if (w2 == 2) begin br_taken = 1'b1; br_addr = 16'h0040; phase = 1; end
        end
        1: begin
          br_taken = 1'b0;
          total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL br_flush: valid=%b want 0", ir_valid); end
          total++; if (fetch_busy !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h2) begin bad++; $display("FAIL br_drain: busy=%b req=%b addr=%h want 1/1/0002", fetch_busy, imem_req, imem_addr); end
          push_exp(16'h0040); push_exp(16'h0041);
          phase = 2;
        end
        2: begin
          if (imem_req && imem_addr != 16'h2) begin
            total++; if (imem_addr !== 16'h0040) begin bad++; $display("FAIL br_target: got %h want 0040", imem_addr); end
            phase = 3;
          end
        end
        3: if (nconsumed >= 4) begin ir_ready = 1'b0; phase = 4; end
        default: ;
      endcase
    end
    total++; if (phase != 4) begin bad++; $display("FAIL br_timeout: phase=%0d want 4", phase); end
    ir_ready = 1'b0;
  endtask

  task automatic test_halt_wrap();
    int phase, hc;
    apply_reset();
    lat = 2;
    ir_ready = 1'b1;
    for (int a = 0; a < 6; a++) push_exp(16'(a));
    phase = 0; hc = 0;
    for (int c = 0; c < 200 && phase < 5; c++) begin
      @(negedge clk);
      if (ir_valid && ir_ready) begin
        total++; nconsumed++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL halt_extra: got %h/%h want none", ir, ir_pc); end
        else begin
          e = exp_q.pop_front();
          if ({ir, ir_pc} !== e) begin bad++; $display("FAIL halt_data: got %h/%h want %h/%h", ir, ir_pc, e[47:16], e[15:0]); end
        end
      end
      case (phase)
        0: if (imem_req && imem_addr == 16'h5) begin halt = 1'b1; phase = 1; end
        1: begin
          hc++;
          if (hc == 10) begin
            total++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin bad++; $display("FAIL halt_stop: req=%b busy=%b want 0/0", imem_req, fetch_busy); end
            total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_addr5: pending=%0d want 0", exp_q.size()); end
            halt = 1'b0;
            phase = 2;
          end
        end
        2: if (imem_req) begin
          total++; if (imem_addr !== 16'h6) begin bad++; $display("FAIL halt_resume: got %h want 0006", imem_addr); end
          br_taken = 1'b1; br_addr = 16'hFFFF;
          phase = 3;
        end
        3: begin
          br_taken = 1'b0;
          push_exp(16'hFFFF); push_exp(16'h0000); push_exp(16'h0001);
          phase = 4;
        end
        4: if (nconsumed >= 9) begin ir_ready = 1'b0; phase = 5; end
        default: ;
      endcase
    end
    total++; if (phase != 5) begin bad++; $display("FAIL halt_timeout: phase=%0d want 5", phase); end
    ir_ready = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    lat = 3;
    ir_ready = 1'b0;
    push_exp(16'h0);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (ir_valid && imem_req) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rmid_setup: seen=%b want 1", seen); end
    rst_f = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || fetch_busy !== 1'b0) begin bad++; $display("FAIL rmid_clear: req=%b valid=%b busy=%b want 0/0/0", imem_req, ir_valid, fetch_busy); end
    rst_f = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin bad++; $display("FAIL rmid_restart: req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ir_valid) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rmid_timeout: no valid, want valid"); end
    ir_ready = 1'b1;
    if (ir_valid && ir_ready) begin
      total++;
      e = exp_q.pop_front();
      if ({ir, ir_pc} !== e) begin bad++; $display("FAIL rmid_data: got %h/%h want %h/%h", ir, ir_pc, e[47:16], e[15:0]); end
    end
    @(negedge clk);
    ir_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_streaming();
    test_branch();
    test_halt_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
